pipeline_stage_ctrl: RTL and testbench
======================================

// Module: pipeline_stage_ctrl
// PURPOSE
//   Parametrised pipeline load/halt controller for the pipelined processor datapath.
//   Decodes the decode-stage opcode plus hazard and branch requests. Drives the
//   following signals:
//     - PC write
//     - per-stage PC-copy and IR load enables
//     - bubble (flush) enables
//     - cycle-counter enable
//   A STOP opcode drains the older instructions, then halts. Load-use hazards insert
//   multi-cycle bubbles; taken branches flush the front stages.
// PARAMETERS
//   NUM_STAGES    4        pipeline stages holding an IR; stage 0 = fetch, stage 1 = decode (min 2)
//   OPCODE_W      4        opcode width on instr_op
//   STOP_OPCODE   4'b0001  opcode that halts the machine
//   STALL_CYCLES  1        bubbles inserted per hazard (min 1)
// PORTS
//   clock         in   1                       rising-edge clock
//   reset         in   1                       asynchronous, active-high
//   instr_op      in   OPCODE_W                opcode of the instruction in decode (stage 1)
//   instr_valid   in   1                       stage-1 IR holds a real instruction (not a bubble)
//   hazard        in   1                       load-use hazard detected on stage-1 instruction
//   branch_taken  in   1                       branch resolved taken this cycle
//   pc_write      out  1                       PC register write enable
//   pc_load       out  NUM_STAGES-1            PC-copy load enables; pc_load[i] follows ir_load[i+1]
//   ir_load       out  NUM_STAGES              IR load enable per stage
//   ir_flush      out  NUM_STAGES              load a NOP/bubble into that stage's IR
//   counter_on    out  1                       cycle counter enable
//   halted        out  1                       machine is in HALT
// BEHAVIOUR
//   States: RUN, STALL, DRAIN, HALT. State and down-counter cnt are registered.
//   Outputs are decoded combinationally from state and inputs.
//   While reset is high: state=RUN, cnt=0, all outputs 0.
//   Reset mid-STALL/DRAIN/HALT aborts immediately.
//   RUN outputs (default): pc_write=1, all ir_load=1, all pc_load=1, ir_flush=0, counter_on=1.
//   RUN input priority, evaluated each cycle:
//     1. branch_taken: ir_flush[1:0]=2'b11 for that cycle; stay RUN.
//        Any hazard/STOP in stage 1 is discarded.
//     2. hazard & instr_valid:
//        - pc_write=0, ir_load[1:0]=0, pc_load[0]=0, ir_flush[2]=1 (if NUM_STAGES>2)
//        - if STALL_CYCLES>1: cnt<=STALL_CYCLES-1 and go to STALL
//     3. instr_valid & instr_op==STOP_OPCODE:
//        - same freeze as a hazard
//        - NUM_STAGES>2: cnt<=NUM_STAGES-3 and go to DRAIN
//        - NUM_STAGES==2: go to HALT directly
//   STALL: same outputs as a hazard cycle; cnt decrements.
//     Leave to RUN after the cycle where cnt==0.
//     branch_taken/hazard inputs are ignored while in STALL.
//   DRAIN: freeze outputs (pc_write=0, ir_load[1:0]=0, pc_load[0]=0).
//     Stages >=2 load; ir_flush[2]=1; counter_on=1.
//     Enter HALT after the cycle where cnt==0.
//     Total freeze+drain = NUM_STAGES-2 cycles, so every older instruction retires.
//     Inputs are ignored.
//   HALT: all load/flush/write enables 0, counter_on=0, halted=1.
//     Terminal unless the resume feature below is compiled in.
//   A STOP opcode arriving while STALL resolves is re-evaluated in RUN.
//     STOP never overrides an active stall.
//   Outputs are mutually consistent: ir_flush[k]=1 implies ir_load[k]=1.
// CONFIGURATION
//   PIPE_CTRL_RESUME_EN defined:
//     - adds input resume (1 bit)
//     - resume=1 in HALT: next cycle enters RUN with pc_write=1, halted=0
//     - ir_flush[1:0]=2'b11 on that first RUN cycle
//     - resume is ignored outside HALT
//   PIPE_CTRL_RESUME_EN undefined:
//     - no resume port
//     - HALT is left only by reset
// TESTING (NUM_STAGES=4, STALL_CYCLES=2 unless stated)
//   1. Reset held 3 cycles, then released with no events
//      -> all outputs 0 during reset
//      -> then pc_write=1, ir_load=4'b1111, counter_on=1
//   2. instr_valid=1, instr_op=4'b0001 for one cycle
//      -> 2 cycles with pc_write=0, ir_load=4'b1100
//      -> then halted=1, counter_on=0, ir_load=0 indefinitely
//   3. hazard=1 for one cycle
//      -> exactly 2 cycles of pc_write=0, ir_load=4'b1100, ir_flush=4'b0100
//      -> back to RUN
//   4. hazard=1 and branch_taken=1 together
//      -> single cycle ir_flush=4'b0011, pc_write=1, no STALL entry
//   5. reset asserted asynchronously mid-DRAIN
//      -> outputs 0 before the next clock edge
//      -> RUN after release
//   6. With PIPE_CTRL_RESUME_EN: halt, then resume=1 for one cycle
//      -> next cycle pc_write=1, halted=0, ir_flush=4'b0011

Source files
------------

// File: rtl/pipeline_stage_ctrl.sv
// Pipeline load/halt controller: stalls, branch flushes, STOP drain and halt.
// Define PIPE_CTRL_RESUME_EN to add a resume input that restarts from HALT.
module pipeline_stage_ctrl #(
    parameter int                  NUM_STAGES   = 4,
    parameter int                  OPCODE_W     = 4,
    parameter logic [OPCODE_W-1:0] STOP_OPCODE  = OPCODE_W'(1),
    parameter int                  STALL_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   instr_op,
    input  logic                  instr_valid,
    input  logic                  hazard,
    input  logic                  branch_taken,
`ifdef PIPE_CTRL_RESUME_EN
    input  logic                  resume,
`endif
    output logic                  pc_write,
    output logic [NUM_STAGES-2:0] pc_load,
    output logic [NUM_STAGES-1:0] ir_load,
    output logic [NUM_STAGES-1:0] ir_flush,
    output logic                  counter_on,
    output logic                  halted
);

    localparam int CW      = $clog2(STALL_CYCLES + NUM_STAGES + 1);
    localparam int STALL_N = STALL_CYCLES - 1;
    localparam int DRAIN_N = (NUM_STAGES > 2) ? NUM_STAGES - 3 : 0;

    localparam logic [NUM_STAGES-1:0] FRZ_LOAD  = ~NUM_STAGES'(3);
    localparam logic [NUM_STAGES-1:0] FRZ_FLUSH = NUM_STAGES'(4);
    localparam logic [NUM_STAGES-1:0] BR_FLUSH  = NUM_STAGES'(3);

    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rsm_flush;

    logic is_stop;
    logic do_br;
    logic do_frz;

    always_comb begin
        is_stop = instr_valid && (instr_op == STOP_OPCODE);
        do_br   = (state == RUN) && (branch_taken || rsm_flush);
        do_frz  = (state == RUN) && !do_br && instr_valid
                  && (hazard || is_stop);
    end

    // cnt holds the freeze cycles still to come after the current one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            rsm_flush <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    rsm_flush <= 1'b0;
                    if (do_frz) begin
                        if (hazard) begin
                            if (STALL_N > 0) begin
                                cnt   <= CW'(STALL_N);
                                state <= STALL;
                            end
                        end else if (DRAIN_N > 0) begin
                            cnt   <= CW'(DRAIN_N);
                            state <= DRAIN;
                        end else begin
                            state <= HALT;
                        end
                    end
                end
                STALL: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1))
                        state <= RUN;
                end
                DRAIN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1))
                        state <= HALT;
                end
                HALT: begin
`ifdef PIPE_CTRL_RESUME_EN
                    if (resume) begin
                        state     <= RUN;
                        rsm_flush <= 1'b1;
                    end
`endif
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_load    = '0;
        ir_flush   = '0;
        counter_on = 1'b0;
        halted     = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    counter_on = 1'b1;
                    if (do_frz) begin
                        ir_load  = FRZ_LOAD;
                        ir_flush = FRZ_FLUSH;
                    end else begin
                        pc_write = 1'b1;
                        ir_load  = '1;
                        ir_flush = do_br ? BR_FLUSH : '0;
                    end
                end
                STALL, DRAIN: begin
                    counter_on = 1'b1;
                    ir_load    = FRZ_LOAD;
                    ir_flush   = FRZ_FLUSH;
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
        pc_load = ir_load[NUM_STAGES-1:1];
    end

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Bench for pipeline_stage_ctrl: vector table, corner sequences, random vs model.
module tb_pipeline_stage_ctrl;

    localparam int         NS   = 4;
    localparam int         SC   = 2;
    localparam logic [3:0] STOP = 4'b0001;

    localparam logic [13:0] E_RUN = {1'b1, 4'b1111, 3'b111, 4'b0000, 1'b1, 1'b0};
    localparam logic [13:0] E_BR  = {1'b1, 4'b1111, 3'b111, 4'b0011, 1'b1, 1'b0};
    localparam logic [13:0] E_FRZ = {1'b0, 4'b1100, 3'b110, 4'b0100, 1'b1, 1'b0};
    localparam logic [13:0] E_HLT = {1'b0, 4'b0000, 3'b000, 4'b0000, 1'b0, 1'b1};
    localparam logic [13:0] E_RST = 14'd0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] instr_op = 4'd0;
    logic       instr_valid = 1'b0;
    logic       hazard = 1'b0;
    logic       branch_taken = 1'b0;
`ifdef PIPE_CTRL_RESUME_EN
    logic       resume = 1'b0;
`endif
    logic       pc_write;
    logic [2:0] pc_load;
    logic [3:0] ir_load;
    logic [3:0] ir_flush;
    logic       counter_on;
    logic       halted;
    logic [13:0] act;

    int checks = 0;
    int failures = 0;

    pipeline_stage_ctrl #(
        .NUM_STAGES(NS), .OPCODE_W(4),
        .STOP_OPCODE(STOP), .STALL_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset),
        .instr_op(instr_op), .instr_valid(instr_valid),
        .hazard(hazard), .branch_taken(branch_taken),
`ifdef PIPE_CTRL_RESUME_EN
        .resume(resume),
`endif
        .pc_write(pc_write), .pc_load(pc_load),
        .ir_load(ir_load), .ir_flush(ir_flush),
        .counter_on(counter_on), .halted(halted)
    );

    always #5 clock = ~clock;

    assign act = {pc_write, ir_load, pc_load, ir_flush, counter_on, halted};

    typedef struct {
        logic v, h, b;
        logic [3:0] op;
        logic [13:0] e;
        string nm;
    } vec_t;

    vec_t tab[17];

    // behavioural model: freeze cycles left, pending halt, forced flush
    int frz_rem;
    bit stop_pend, m_halt, force_br;

    task automatic model_reset();
        frz_rem = 0; stop_pend = 0; m_halt = 0; force_br = 0;
    endtask

    task automatic model_step(input logic v, h, b, input logic [3:0] op,
                              input logic rs, output logic [13:0] e);
        if (m_halt) begin
            e = E_HLT;
            if (rs) begin m_halt = 0; force_br = 1; end
        end else if (frz_rem > 0) begin
            e = E_FRZ;
            frz_rem--;
            if (frz_rem == 0 && stop_pend) begin m_halt = 1; stop_pend = 0; end
        end else if (b || force_br) begin
            e = E_BR;
            force_br = 0;
        end else if (v && (h || op == STOP)) begin
            e = E_FRZ;
            if (h) frz_rem = SC - 1;
            else begin
                frz_rem = NS - 3;
                if (frz_rem == 0) m_halt = 1; else stop_pend = 1;
            end
        end else begin
            e = E_RUN;
        end
    endtask

    function automatic vec_t mk(logic v, h, b, logic [3:0] op,
                                logic [13:0] e, string nm);
        vec_t r;
        r.v = v; r.h = h; r.b = b; r.op = op; r.e = e; r.nm = nm;
        return r;
    endfunction

    task automatic check(input string nm, input logic [13:0] a, e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, a, e);
        end
    endtask

    task automatic apply(input logic v, h, b, input logic [3:0] op,
                         input logic [13:0] e, input string nm);
        instr_valid = v; hazard = h; branch_taken = b; instr_op = op;
        @(negedge clock);
        check(nm, act, e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        check("reset_hold", act, E_RST);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [13:0] e;
        logic v, h, b, rs;
        logic [3:0] op;

        tab[0]  = mk(0, 0, 0, 4'h0, E_RUN, "idle");
        tab[1]  = mk(0, 0, 1, 4'h0, E_BR,  "branch");
        tab[2]  = mk(1, 1, 0, 4'h5, E_FRZ, "hazard");
        tab[3]  = mk(0, 0, 0, 4'h0, E_FRZ, "stall");
        tab[4]  = mk(0, 0, 0, 4'h0, E_RUN, "post_stall");
        tab[5]  = mk(1, 1, 1, 4'h5, E_BR,  "hazard_branch");
        tab[6]  = mk(0, 0, 0, 4'h0, E_RUN, "after_hz_br");
        tab[7]  = mk(0, 1, 0, 4'h5, E_RUN, "hazard_invalid");
        tab[8]  = mk(0, 0, 0, STOP, E_RUN, "stop_invalid");
        tab[9]  = mk(1, 1, 0, 4'h3, E_FRZ, "hazard2");
        tab[10] = mk(0, 0, 1, 4'h0, E_FRZ, "branch_in_stall");
        tab[11] = mk(1, 0, 0, 4'h2, E_RUN, "post_stall2");
        tab[12] = mk(1, 0, 0, STOP, E_FRZ, "stop");
        tab[13] = mk(1, 0, 0, STOP, E_FRZ, "drain");
        tab[14] = mk(0, 0, 0, 4'h0, E_HLT, "halt");
        tab[15] = mk(0, 0, 1, 4'h0, E_HLT, "halt_branch");
        tab[16] = mk(1, 1, 0, 4'h0, E_HLT, "halt_hazard");

        model_reset();
        repeat (3) begin
            @(negedge clock);
            check("reset", act, E_RST);
        end
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 17; i++)
            apply(tab[i].v, tab[i].h, tab[i].b, tab[i].op, tab[i].e, tab[i].nm);

        // STOP while a stall resolves is held off, then taken in RUN
        do_reset();
        apply(1, 1, 0, 4'h4, E_FRZ, "hz_then_stop");
        apply(1, 0, 0, STOP, E_FRZ, "stop_in_stall");
        apply(1, 0, 0, STOP, E_FRZ, "stop_in_run");
        apply(0, 0, 0, 4'h0, E_FRZ, "drain2");
        apply(0, 0, 0, 4'h0, E_HLT, "halt2");

        // asynchronous reset in the middle of DRAIN
        do_reset();
        apply(1, 0, 0, STOP, E_FRZ, "stop3");
        instr_valid = 0; instr_op = 4'h0;
        #2 reset = 1'b1;
        #1 check("async_reset", act, E_RST);
        @(posedge clock);
        #1 reset = 1'b0;
        apply(0, 0, 0, 4'h0, E_RUN, "run_after_reset");
        apply(0, 0, 0, 4'h0, E_RUN, "run_after_reset2");

`ifdef PIPE_CTRL_RESUME_EN
        apply(1, 0, 0, STOP, E_FRZ, "stop4");
        apply(0, 0, 0, 4'h0, E_FRZ, "drain4");
        apply(0, 0, 0, 4'h0, E_HLT, "halt4");
        resume = 1'b1;
        apply(0, 0, 0, 4'h0, E_HLT, "resume_cycle");
        resume = 1'b0;
        apply(0, 0, 0, 4'h0, E_BR, "resumed");
        apply(0, 0, 0, 4'h0, E_RUN, "run_after_resume");
        resume = 1'b1;
        apply(0, 0, 0, 4'h0, E_RUN, "resume_in_run");
        resume = 1'b0;
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (m_halt && ($urandom % 8 == 0)) begin
                do_reset();
            end else begin
                v  = ($urandom % 4) != 0;
                h  = ($urandom % 5) == 0;
                b  = ($urandom % 6) == 0;
                op = ($urandom % 10 == 0) ? STOP : 4'($urandom % 16);
                rs = 1'b0;
`ifdef PIPE_CTRL_RESUME_EN
                rs = ($urandom % 3) == 0;
                resume = rs;
`endif
                model_step(v, h, b, op, rs, e);
                apply(v, h, b, op, e, "random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
